tile_grid_render: RTL and testbench
===================================

# tile_grid_render

Parametrised successor to the fixed 5×6 square renderer: converts per-pixel grid coordinates, the current square's palette index and streamed 2-bit glyph data into Tiny VGA pmod colour. Adds a configurable grid and tile geometry, a row-reveal flip animation sequenced per frame, and a blinking selection outline. Sits between the VGA timing generator / flash font streamer and the output pins; game logic drives `palette_index` and `reveal_*`.

## Interface
- `GRID_COLS`, 5, tile columns drawn (grid columns 1..GRID_COLS)
- `GRID_ROWS`, 6, tile rows drawn (grid rows 1..GRID_ROWS)
- `TILE`, 76, tile pitch in pixels; `local_x/y` range 0..TILE-1
- `GLYPH_X0`/`GLYPH_Y0`, 22/24, glyph box origin; box is 32×32
- `FLIP_FRAMES`, 8, frames per tile flip; must be even, ≥2
- `SQUASH_STEP`, 9, rows blanked per flip phase step; `SQUASH_STEP*(FLIP_FRAMES/2-1) < TILE/2`
- `BLINK_FRAMES`, 32, frames per selection-outline blink half-period
- `clk`  in  1  pixel clock
- `rst`  in  1  asynchronous, active-high reset
- `column`  in  4  grid column of current pixel
- `row`  in  4  grid row of current pixel
- `local_x`, `local_y`  in  8  pixel position inside tile
- `frame_start`  in  1  one-cycle pulse per frame (start of vblank)
- `pixel_data`  in  2  glyph gradient level, valid one cycle after coordinates
- `pixel_data_valid`  in  1  qualifies `pixel_data` for the previous cycle's coordinates
- `palette_index`  in  3  final style of current square (0..6 as defined in package)
- `reveal_start`  in  1  pulse: begin flip of `reveal_row`
- `reveal_row`  in  4  grid row to reveal, sampled with `reveal_start`
- `reveal_busy`  out  1  flip sequence in progress
- `reveal_done`  out  1  one-cycle pulse when last tile finishes
- `red`, `green`, `blue`  out  2 each  registered colour

## Operation
- Regions per tile (only when 1≤row≤GRID_ROWS, 1≤column≤GRID_COLS, else black): glyph box → gradient[pixel_data] or 00_00_11 if last `pixel_data_valid` low; inset 6..TILE-7 → gradient[0]; inset 3..TILE-4 → border colour; else black.
- Effective palette: `palette_index`, overridden by flip/blink rules below.
- Sequencer FSM: IDLE → FLIP on `reveal_start` (ignored while busy); latches row, `flip_col`=0, `phase`=0. In FLIP each `frame_start` increments `phase`; at `phase`=FLIP_FRAMES-1 it wraps to 0 and `flip_col`++; when `flip_col`=GRID_COLS-1 wraps → IDLE, `reveal_done` pulses that cycle.
- In the reveal row: columns > `flip_col`+1 (1-based) use palette 0; the flipping column uses palette 0 while `phase`<FLIP_FRAMES/2, else `palette_index`; columns already flipped use `palette_index`.
- Squash on flipping tile: s = phase*SQUASH_STEP for first half, (FLIP_FRAMES-1-phase)*SQUASH_STEP for second half; pixels with `local_y`<s or `local_y`≥TILE-s output black.
- Blink: free-running counter advances on `frame_start`, toggles `blink` every BLINK_FRAMES frames; while `blink`=1, palettes 1 and 3 use border of 0 and 2 respectively.
- `reveal_start` coincident with `frame_start` in IDLE: starts at phase 0; that `frame_start` not counted.
- Geometry comparisons 8-bit unsigned; no wrap.

## Timing
- Colour outputs registered: latency 1 cycle from coordinates/palette/`pixel_data_valid`; `pixel_data` used directly (already 1 cycle late).
- Reset values: `{red,green,blue}`=00_00_11, `reveal_busy`=0, `reveal_done`=0, state IDLE, blink counter 0, `blink`=0, last-valid flag 0.
- `reveal_busy` rises the cycle after `reveal_start`, falls with `reveal_done`.
- Total reveal = GRID_COLS*FLIP_FRAMES `frame_start` pulses.
- Reset mid-flip: immediate return to IDLE, no `reveal_done`.

## Structure
- `tile_render_pkg`: palette constants (30-bit, 4 gradient + border), palette-index enum, sequencer state enum, black/no-data colour constants.
- Sub-module `tile_flip_sequencer`: FSM, `flip_col`, `phase`, blink counter, busy/done; renderer consumes its state combinationally.

## Test plan
- Reset then idle pixels: outputs 00_00_11 during reset; pixel at row 0 → 000000 next cycle.
- Palette 6, row 2 col 3, local (30,30), valid=1, data=2 → 10_11_10 one cycle later; valid=0 → 00_00_11.
- Palette 1 border pixel (4,40): 10_10_10 for 32 frames, 01_01_01 next 32, repeats.
- reveal_start row 3: busy next cycle; after 3 frames col 1 local_y=10 black (s=27); after 4 frames palette switches, s=27; col 2 palette 0 until frame 12.
- 40 `frame_start` pulses → `reveal_done` on 40th, busy falls; `reveal_start` during busy ignored.
- Assert `rst` at frame 17 of reveal → busy 0, all row-3 tiles show `palette_index`, no done pulse.

Source files
------------

// File: rtl/tile_render_pkg.sv
// Shared types and colour constants for the tile grid renderer.
// Colours are packed {r[1:0], g[1:0], b[1:0]}.
`default_nettype none

package tile_render_pkg;

  typedef enum logic [2:0] {
    PAL_EMPTY   = 3'd0,
    PAL_ACTIVE  = 3'd1,
    PAL_ABSENT  = 3'd2,
    PAL_HINT    = 3'd3,
    PAL_PRESENT = 3'd4,
    PAL_ERROR   = 3'd5,
    PAL_CORRECT = 3'd6
  } palette_idx_e;

  typedef enum logic [0:0] {
    SEQ_IDLE = 1'b0,
    SEQ_FLIP = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic [5:0] border;
    logic [5:0] grad3;
    logic [5:0] grad2;
    logic [5:0] grad1;
    logic [5:0] grad0;
  } palette_t;

  localparam logic [5:0] COLOR_BLACK   = 6'b00_00_00;
  localparam logic [5:0] COLOR_NO_DATA = 6'b00_00_11;

  localparam palette_t PALETTE_EMPTY   = '{6'b01_01_01, 6'b11_11_11, 6'b10_10_10, 6'b01_01_01, 6'b00_00_00};
  localparam palette_t PALETTE_ACTIVE  = '{6'b10_10_10, 6'b11_11_11, 6'b10_10_10, 6'b01_01_01, 6'b00_00_00};
  localparam palette_t PALETTE_ABSENT  = '{6'b01_01_10, 6'b11_11_11, 6'b11_11_11, 6'b10_10_10, 6'b01_01_01};
  localparam palette_t PALETTE_HINT    = '{6'b11_11_00, 6'b11_11_11, 6'b10_10_10, 6'b01_01_01, 6'b00_00_00};
  localparam palette_t PALETTE_PRESENT = '{6'b11_10_00, 6'b11_11_10, 6'b11_11_01, 6'b11_10_01, 6'b10_10_00};
  localparam palette_t PALETTE_ERROR   = '{6'b11_00_00, 6'b11_10_10, 6'b11_01_01, 6'b11_00_00, 6'b10_00_00};
  localparam palette_t PALETTE_CORRECT = '{6'b00_11_00, 6'b11_11_11, 6'b10_11_10, 6'b01_10_01, 6'b00_10_00};

  // Index 7 is unused by the game and falls back to the empty style.
  function automatic palette_t palette_lookup(input logic [2:0] idx);
    palette_t p;
    case (idx)
      PAL_ACTIVE:  p = PALETTE_ACTIVE;
      PAL_ABSENT:  p = PALETTE_ABSENT;
      PAL_HINT:    p = PALETTE_HINT;
      PAL_PRESENT: p = PALETTE_PRESENT;
      PAL_ERROR:   p = PALETTE_ERROR;
      PAL_CORRECT: p = PALETTE_CORRECT;
      default:     p = PALETTE_EMPTY;
    endcase
    return p;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tile_flip_sequencer.sv
// Per-frame row-reveal sequencer (column/phase stepping) and selection blink timer.
`default_nettype none

module tile_flip_sequencer
  import tile_render_pkg::*;
#(
  parameter int GRID_COLS    = 5,
  parameter int FLIP_FRAMES  = 8,
  parameter int BLINK_FRAMES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       reveal_start,
  input  logic [3:0] reveal_row,
  output logic       busy,
  output logic       done,
  output logic [3:0] row_sel,
  output logic [3:0] flip_col,
  output logic [7:0] phase,
  output logic       blink
);

  localparam logic [7:0]  LAST_PHASE = 8'(FLIP_FRAMES - 1);
  localparam logic [3:0]  LAST_COL   = 4'(GRID_COLS - 1);
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);

  seq_state_e  state, state_next;
  logic [3:0]  row_next, col_next;
  logic [7:0]  phase_next;
  logic        done_next;
  logic [15:0] blink_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SEQ_IDLE;
      row_sel  <= 4'd0;
      flip_col <= 4'd0;
      phase    <= 8'd0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      row_sel  <= row_next;
      flip_col <= col_next;
      phase    <= phase_next;
      done     <= done_next;
    end
  end

  // A frame_start arriving with reveal_start in IDLE is not counted as a step.
  always_comb begin
    state_next = state;
    row_next   = row_sel;
    col_next   = flip_col;
    phase_next = phase;
    done_next  = 1'b0;
    case (state)
      SEQ_IDLE: begin
        if (reveal_start) begin
          state_next = SEQ_FLIP;
          row_next   = reveal_row;
          col_next   = 4'd0;
          phase_next = 8'd0;
        end
      end
      SEQ_FLIP: begin
        if (frame_start) begin
          if (phase == LAST_PHASE) begin
            phase_next = 8'd0;
            if (flip_col == LAST_COL) begin
              state_next = SEQ_IDLE;
              col_next   = 4'd0;
              done_next  = 1'b1;
            end else begin
              col_next = flip_col + 4'd1;
            end
          end else begin
            phase_next = phase + 8'd1;
          end
        end
      end
      default: state_next = SEQ_IDLE;
    endcase
  end

  assign busy = (state == SEQ_FLIP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= 16'd0;
      blink     <= 1'b0;
    end else if (frame_start) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= 16'd0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tile_grid_render.sv
// Tile grid renderer: maps grid/tile coordinates, palette and glyph data to
// registered Tiny VGA colour, with row-reveal flip and selection-outline blink.
`default_nettype none

module tile_grid_render
  import tile_render_pkg::*;
#(
  parameter int GRID_COLS    = 5,
  parameter int GRID_ROWS    = 6,
  parameter int TILE         = 76,
  parameter int GLYPH_X0     = 22,
  parameter int GLYPH_Y0     = 24,
  parameter int FLIP_FRAMES  = 8,
  parameter int SQUASH_STEP  = 9,
  parameter int BLINK_FRAMES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] column,
  input  logic [3:0] row,
  input  logic [7:0] local_x,
  input  logic [7:0] local_y,
  input  logic       frame_start,
  input  logic [1:0] pixel_data,
  input  logic       pixel_data_valid,
  input  logic [2:0] palette_index,
  input  logic       reveal_start,
  input  logic [3:0] reveal_row,
  output logic       reveal_busy,
  output logic       reveal_done,
  output logic [1:0] red,
  output logic [1:0] green,
  output logic [1:0] blue
);

  localparam logic [3:0] COLS_L   = 4'(GRID_COLS);
  localparam logic [3:0] ROWS_L   = 4'(GRID_ROWS);
  localparam logic [7:0] TILE_L   = 8'(TILE);
  localparam logic [7:0] GX_LO    = 8'(GLYPH_X0);
  localparam logic [7:0] GX_HI    = 8'(GLYPH_X0 + 31);
  localparam logic [7:0] GY_LO    = 8'(GLYPH_Y0);
  localparam logic [7:0] GY_HI    = 8'(GLYPH_Y0 + 31);
  localparam logic [7:0] INNER_LO = 8'd6;
  localparam logic [7:0] INNER_HI = 8'(TILE - 7);
  localparam logic [7:0] RING_LO  = 8'd3;
  localparam logic [7:0] RING_HI  = 8'(TILE - 4);
  localparam logic [7:0] HALF     = 8'(FLIP_FRAMES / 2);
  localparam logic [7:0] LAST_PH  = 8'(FLIP_FRAMES - 1);

  logic       busy, blink;
  logic [3:0] row_sel, flip_col;
  logic [7:0] phase;

  tile_flip_sequencer #(
    .GRID_COLS    (GRID_COLS),
    .FLIP_FRAMES  (FLIP_FRAMES),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_seq (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .reveal_start (reveal_start),
    .reveal_row   (reveal_row),
    .busy         (busy),
    .done         (reveal_done),
    .row_sel      (row_sel),
    .flip_col     (flip_col),
    .phase        (phase),
    .blink        (blink)
  );

  assign reveal_busy = busy;

  logic       in_grid, in_reveal_row, flip_tile, first_half;
  logic       in_glyph, in_inner, in_ring, squashed;
  logic [3:0] flip_col_1b;
  logic [2:0] eff_idx;
  logic [7:0] squash;
  logic [5:0] border, glyph_color, color_next;
  palette_t   pal;

  always_comb begin
    flip_col_1b   = flip_col + 4'd1;
    first_half    = (phase < HALF);
    in_grid       = (row >= 4'd1) && (row <= ROWS_L) && (column >= 4'd1) && (column <= COLS_L);
    in_reveal_row = busy && (row == row_sel);
    flip_tile     = in_reveal_row && (column == flip_col_1b);

    // Unrevealed tiles and the face-down half of the flip show the empty style.
    eff_idx = palette_index;
    if (in_reveal_row) begin
      if (column > flip_col_1b)
        eff_idx = PAL_EMPTY;
      else if (flip_tile && first_half)
        eff_idx = PAL_EMPTY;
    end

    pal    = palette_lookup(eff_idx);
    border = pal.border;
    if (blink && (eff_idx == PAL_ACTIVE))
      border = PALETTE_EMPTY.border;
    else if (blink && (eff_idx == PAL_HINT))
      border = PALETTE_ABSENT.border;

    squash   = first_half ? 8'(phase * SQUASH_STEP) : 8'((LAST_PH - phase) * SQUASH_STEP);
    squashed = flip_tile && ((local_y < squash) || (local_y >= TILE_L - squash));

    in_glyph = (local_x >= GX_LO) && (local_x <= GX_HI) && (local_y >= GY_LO) && (local_y <= GY_HI);
    in_inner = (local_x >= INNER_LO) && (local_x <= INNER_HI) &&
               (local_y >= INNER_LO) && (local_y <= INNER_HI);
    in_ring  = (local_x >= RING_LO) && (local_x <= RING_HI) &&
               (local_y >= RING_LO) && (local_y <= RING_HI);

    case (pixel_data)
      2'd0:    glyph_color = pal.grad0;
      2'd1:    glyph_color = pal.grad1;
      2'd2:    glyph_color = pal.grad2;
      default: glyph_color = pal.grad3;
    endcase

    color_next = COLOR_BLACK;
    if (in_grid && !squashed) begin
      if (in_glyph)
        color_next = pixel_data_valid ? glyph_color : COLOR_NO_DATA;
      else if (in_inner)
        color_next = pal.grad0;
      else if (in_ring)
        color_next = border;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      {red, green, blue} <= COLOR_NO_DATA;
    else
      {red, green, blue} <= color_next;
  end

endmodule

`default_nettype wire

// File: tb/tb_tile_grid_render.sv
// Directed bench for tile_grid_render: static pixel vector table plus
// blink and reveal-sequence scenarios with hand-computed colours.
`default_nettype none

module tb_tile_grid_render;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] column, row, reveal_row;
  logic [7:0] local_x, local_y;
  logic       frame_start, pixel_data_valid, reveal_start;
  logic [1:0] pixel_data;
  logic [2:0] palette_index;
  logic       reveal_busy, reveal_done;
  logic [1:0] red, green, blue;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tile_grid_render dut (
    .clk              (clk),
    .rst              (rst),
    .column           (column),
    .row              (row),
    .local_x          (local_x),
    .local_y          (local_y),
    .frame_start      (frame_start),
    .pixel_data       (pixel_data),
    .pixel_data_valid (pixel_data_valid),
    .palette_index    (palette_index),
    .reveal_start     (reveal_start),
    .reveal_row       (reveal_row),
    .reveal_busy      (reveal_busy),
    .reveal_done      (reveal_done),
    .red              (red),
    .green            (green),
    .blue             (blue)
  );

  typedef struct {
    string      name;
    logic [2:0] pal;
    logic [3:0] r;
    logic [3:0] c;
    logic [7:0] lx;
    logic [7:0] ly;
    logic       v;
    logic [1:0] d;
    logic [5:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
      tick(1);
    end
  endtask

  task automatic pix(input string name, input logic [2:0] pal, input logic [3:0] r, input logic [3:0] c,
                     input logic [7:0] lx, input logic [7:0] ly, input logic [5:0] exp);
    palette_index = pal; row = r; column = c; local_x = lx; local_y = ly;
    tick(1);
    check(name, {red, green, blue}, exp);
  endtask

  initial begin
    rst = 1'b1; column = 4'd0; row = 4'd0; local_x = 8'd0; local_y = 8'd0;
    frame_start = 1'b0; pixel_data = 2'd0; pixel_data_valid = 1'b0;
    palette_index = 3'd0; reveal_start = 1'b0; reveal_row = 4'd0;

    vecs.push_back('{"glyph_d2",      3'd6, 4'd2, 4'd3, 8'd30, 8'd30, 1'b1, 2'd2, 6'b10_11_10});
    vecs.push_back('{"glyph_nodata",  3'd6, 4'd2, 4'd3, 8'd30, 8'd30, 1'b0, 2'd2, 6'b00_00_11});
    vecs.push_back('{"row0",          3'd6, 4'd0, 4'd3, 8'd30, 8'd30, 1'b1, 2'd2, 6'b00_00_00});
    vecs.push_back('{"col0",          3'd6, 4'd2, 4'd0, 8'd10, 8'd10, 1'b1, 2'd2, 6'b00_00_00});
    vecs.push_back('{"col6",          3'd6, 4'd2, 4'd6, 8'd10, 8'd10, 1'b1, 2'd2, 6'b00_00_00});
    vecs.push_back('{"row7",          3'd6, 4'd7, 4'd1, 8'd10, 8'd10, 1'b1, 2'd2, 6'b00_00_00});
    vecs.push_back('{"inner",         3'd6, 4'd2, 4'd3, 8'd10, 8'd10, 1'b1, 2'd2, 6'b00_10_00});
    vecs.push_back('{"inner_lo",      3'd6, 4'd1, 4'd1, 8'd6,  8'd6,  1'b1, 2'd2, 6'b00_10_00});
    vecs.push_back('{"ring_5",        3'd6, 4'd6, 4'd5, 8'd5,  8'd40, 1'b1, 2'd2, 6'b00_11_00});
    vecs.push_back('{"ring_lo",       3'd6, 4'd2, 4'd3, 8'd3,  8'd40, 1'b1, 2'd2, 6'b00_11_00});
    vecs.push_back('{"outer_lo",      3'd6, 4'd2, 4'd3, 8'd2,  8'd40, 1'b1, 2'd2, 6'b00_00_00});
    vecs.push_back('{"ring_hi",       3'd6, 4'd2, 4'd3, 8'd72, 8'd40, 1'b1, 2'd2, 6'b00_11_00});
    vecs.push_back('{"outer_hi",      3'd6, 4'd2, 4'd3, 8'd73, 8'd40, 1'b1, 2'd2, 6'b00_00_00});
    vecs.push_back('{"inner_hi",      3'd6, 4'd2, 4'd3, 8'd69, 8'd40, 1'b1, 2'd2, 6'b00_10_00});
    vecs.push_back('{"pal1_border",   3'd1, 4'd2, 4'd2, 8'd4,  8'd40, 1'b1, 2'd0, 6'b10_10_10});
    vecs.push_back('{"glyph_corner0", 3'd4, 4'd3, 4'd4, 8'd22, 8'd24, 1'b1, 2'd0, 6'b10_10_00});
    vecs.push_back('{"glyph_corner1", 3'd4, 4'd3, 4'd4, 8'd53, 8'd55, 1'b1, 2'd3, 6'b11_11_10});
    vecs.push_back('{"glyph_edge_x",  3'd4, 4'd3, 4'd4, 8'd54, 8'd55, 1'b1, 2'd3, 6'b10_10_00});
    vecs.push_back('{"glyph_d1",      3'd4, 4'd3, 4'd4, 8'd22, 8'd24, 1'b1, 2'd1, 6'b11_10_01});
    vecs.push_back('{"pal3_border",   3'd3, 4'd4, 4'd1, 8'd40, 8'd3,  1'b1, 2'd0, 6'b11_11_00});
    vecs.push_back('{"pal7_border",   3'd7, 4'd4, 4'd1, 8'd4,  8'd40, 1'b1, 2'd0, 6'b01_01_01});
    vecs.push_back('{"pal5_glyph",    3'd5, 4'd5, 4'd2, 8'd40, 8'd40, 1'b1, 2'd3, 6'b11_10_10});
    vecs.push_back('{"pal2_border",   3'd2, 4'd5, 4'd2, 8'd40, 8'd70, 1'b1, 2'd0, 6'b01_01_10});

    // Reset behaviour
    tick(2);
    check("reset_color", {red, green, blue}, 6'b00_00_11);
    check("reset_busy", {5'd0, reveal_busy}, 6'd0);
    check("reset_done", {5'd0, reveal_done}, 6'd0);
    rst = 1'b0;
    tick(1);
    check("idle_row0", {red, green, blue}, 6'b00_00_00);

    // Static pixel table
    foreach (vecs[i]) begin
      palette_index    = vecs[i].pal;
      row              = vecs[i].r;
      column           = vecs[i].c;
      local_x          = vecs[i].lx;
      local_y          = vecs[i].ly;
      pixel_data_valid = vecs[i].v;
      pixel_data       = vecs[i].d;
      tick(1);
      check(vecs[i].name, {red, green, blue}, vecs[i].exp);
    end
    pixel_data_valid = 1'b1;

    // Blink: 32 frames per half period, counted from reset
    frames(31);
    pix("blink_31", 3'd1, 4'd2, 4'd2, 8'd4, 8'd40, 6'b10_10_10);
    frames(1);
    pix("blink_32", 3'd1, 4'd2, 4'd2, 8'd4, 8'd40, 6'b01_01_01);
    pix("blink_pal3", 3'd3, 4'd2, 4'd2, 8'd4, 8'd40, 6'b01_01_10);
    pix("blink_pal6", 3'd6, 4'd2, 4'd2, 8'd4, 8'd40, 6'b00_11_00);
    frames(31);
    pix("blink_63", 3'd1, 4'd2, 4'd2, 8'd4, 8'd40, 6'b01_01_01);
    frames(1);
    pix("blink_64", 3'd1, 4'd2, 4'd2, 8'd4, 8'd40, 6'b10_10_10);

    // Reveal of row 3 with palette 6
    reveal_row = 4'd3; reveal_start = 1'b1;
    tick(1);
    reveal_start = 1'b0;
    check("busy_rise", {5'd0, reveal_busy}, 6'd1);
    pix("f0_col1_border", 3'd6, 4'd3, 4'd1, 8'd4, 8'd10, 6'b01_01_01);
    frames(3);
    pix("f3_col1_squash", 3'd6, 4'd3, 4'd1, 8'd4, 8'd10, 6'b00_00_00);
    pix("f3_col1_pal0", 3'd6, 4'd3, 4'd1, 8'd4, 8'd30, 6'b01_01_01);
    pix("f3_other_row", 3'd6, 4'd2, 4'd1, 8'd4, 8'd10, 6'b00_11_00);
    frames(1);
    pix("f4_col1_squash", 3'd6, 4'd3, 4'd1, 8'd4, 8'd10, 6'b00_00_00);
    pix("f4_col1_pal6", 3'd6, 4'd3, 4'd1, 8'd4, 8'd30, 6'b00_11_00);
    pix("f4_bottom_y48", 3'd6, 4'd3, 4'd1, 8'd4, 8'd48, 6'b00_11_00);
    pix("f4_bottom_y49", 3'd6, 4'd3, 4'd1, 8'd4, 8'd49, 6'b00_00_00);
    pix("f4_col2_pal0", 3'd6, 4'd3, 4'd2, 8'd4, 8'd30, 6'b01_01_01);
    reveal_row = 4'd5; reveal_start = 1'b1;
    tick(1);
    reveal_start = 1'b0;
    check("start_ignored_busy", {5'd0, reveal_busy}, 6'd1);
    pix("start_ignored_row5", 3'd6, 4'd5, 4'd1, 8'd4, 8'd30, 6'b00_11_00);
    frames(4);
    pix("f8_col1_done", 3'd6, 4'd3, 4'd1, 8'd4, 8'd10, 6'b00_11_00);
    pix("f8_col2_pal0", 3'd6, 4'd3, 4'd2, 8'd4, 8'd10, 6'b01_01_01);
    frames(3);
    pix("f11_col2_pal0", 3'd6, 4'd3, 4'd2, 8'd4, 8'd30, 6'b01_01_01);
    frames(1);
    pix("f12_col2_pal6", 3'd6, 4'd3, 4'd2, 8'd4, 8'd30, 6'b00_11_00);
    frames(27);
    check("f39_busy", {5'd0, reveal_busy}, 6'd1);
    check("f39_no_done", {5'd0, reveal_done}, 6'd0);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    check("f40_done", {5'd0, reveal_done}, 6'd1);
    check("f40_busy_fall", {5'd0, reveal_busy}, 6'd0);
    tick(1);
    check("done_one_cycle", {5'd0, reveal_done}, 6'd0);
    pix("after_reveal_col5", 3'd6, 4'd3, 4'd5, 8'd4, 8'd30, 6'b00_11_00);

    // Start coincident with frame_start: that pulse is not counted
    reveal_row = 4'd3; reveal_start = 1'b1; frame_start = 1'b1;
    tick(1);
    reveal_start = 1'b0; frame_start = 1'b0;
    tick(1);
    frames(3);
    pix("coincident_f3_pal0", 3'd6, 4'd3, 4'd1, 8'd4, 8'd30, 6'b01_01_01);
    frames(14);
    check("f17_busy", {5'd0, reveal_busy}, 6'd1);
    pix("f17_col3_pal0", 3'd6, 4'd3, 4'd3, 8'd4, 8'd30, 6'b01_01_01);

    // Reset mid-flip
    rst = 1'b1;
    #1;
    check("midreset_busy", {5'd0, reveal_busy}, 6'd0);
    check("midreset_done", {5'd0, reveal_done}, 6'd0);
    tick(1);
    rst = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      pix($sformatf("post_reset_col%0d", c), 3'd6, 4'd3, 4'(c), 8'd4, 8'd30, 6'b00_11_00);
      check($sformatf("post_reset_nodone%0d", c), {5'd0, reveal_done}, 6'd0);
    end
    frames(8);
    check("post_reset_idle", {5'd0, reveal_busy}, 6'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
